bus_port_fifo: RTL
==================

BUS_PORT_FIFO -- requirements
Module: bus_port_fifo

Interface
REQ-001 SHALL have parameter PCKG_SZ, default 16, meaning packet width in bits (matches bus packet size).
REQ-002 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock for all state; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset (asserted when 0).
REQ-005 SHALL have port wr_en  input  1  device-side push request.
REQ-006 SHALL have port wr_data  input  PCKG_SZ  device-side packet.
REQ-007 SHALL have port pop  input  1  bus-side pop strobe from the bus arbiter.
REQ-008 SHALL have port D_pop  output  PCKG_SZ  head packet presented to the bus.
REQ-009 SHALL have port pndng  output  1  FIFO non-empty, request to the bus.
REQ-010 SHALL have port full  output  1  count equals DEPTH.
REQ-011 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.
REQ-012 SHALL have port clr_flags  input  1  synchronous clear of sticky flags and drop counter.
REQ-013 SHALL have port overflow  output  1  sticky: a write was dropped.
REQ-014 SHALL have port underflow  output  1  sticky: pop arrived while empty.
REQ-015 SHALL have port drop_cnt  output  8  saturating count of dropped writes.

Function
REQ-016 SHALL be a circular buffer with read pointer, write pointer (log2(DEPTH) bits, wrap DEPTH-1 -> 0) and occupancy counter.
REQ-017 SHALL present D_pop show-ahead: D_pop equals head entry combinationally whenever pndng=1; D_pop value when pndng=0 is don't-care but SHALL be 0 after reset.
REQ-018 SHALL drive pndng = (count != 0) and full = (count == DEPTH), both from registered count, no combinational path from pop or wr_en.
REQ-019 SHALL accept a write (store wr_data at write pointer, advance pointer) on a clk edge with wr_en=1 when count<DEPTH, or when count==DEPTH and pop=1 in the same cycle.
REQ-020 SHALL perform a pop (advance read pointer) on a clk edge with pop=1 and count>0; the popped packet is the D_pop value sampled at that edge.
REQ-021 SHALL leave count unchanged on simultaneous accepted write and pop; +1 on write only; -1 on pop only.
REQ-022 SHALL, when empty, ignore pop (no pointer move), set underflow, and still accept a same-cycle write (count 0 -> 1; no fall-through in that cycle).
REQ-023 SHALL, on wr_en=1 with count==DEPTH and pop=0, drop wr_data, leave pointers/count unchanged, set overflow and increment drop_cnt, saturating at 255.
REQ-024 SHALL make written data visible on D_pop/pndng one cycle after the accepting edge (write-to-pndng latency 1).
REQ-025 SHALL apply clr_flags before same-cycle flag events: clr_flags=1 with a simultaneous drop yields overflow=1, drop_cnt=1.
REQ-026 SHALL not modify stored packets other than at the write pointer on accepted writes.

Reset
REQ-027 SHALL, while reset=0, asynchronously force pointers=0, count=0, pndng=0, full=0, overflow=0, underflow=0, drop_cnt=0, D_pop=0.
REQ-028 SHALL discard all buffered packets on reset assertion mid-operation; storage contents need not be cleared.
REQ-029 SHALL ignore wr_en, pop and clr_flags while reset=0 and resume on the first clk edge after reset=1.

Verification
REQ-030 Write 0x1111,0x2222,0x3333 on consecutive cycles, no pop -> pndng=1 one cycle after first write, count=3, D_pop=0x1111; three pops -> D_pop 0x2222, 0x3333, then pndng=0.
REQ-031 Fill DEPTH=8 entries, then wr_en=1 pop=0 with 0xDEAD -> full=1, count=8, overflow=1, drop_cnt=1, 0xDEAD never appears on D_pop.
REQ-032 Full FIFO, wr_en=1 and pop=1 same cycle with 0xBEEF -> count stays 8, head advances, 0xBEEF emerges as eighth pop afterwards.
REQ-033 Empty FIFO, pop=1 and wr_en=1 with 0x00A5 -> underflow=1, count=1, next cycle pndng=1 and D_pop=0x00A5.
REQ-034 Write 300 packets to a full FIFO with pop=0 -> drop_cnt=255 saturated; clr_flags=1 one cycle -> overflow=0, drop_cnt=0.
REQ-035 Write 5 packets, drop reset to 0 asynchronously between edges -> pndng, count, full, flags go 0 immediately; after release, write 0x7777 -> D_pop=0x7777 first.

Source files
------------

// File: rtl/bus_port_fifo.sv
// Bus port FIFO: device side pushes packets, bus arbiter pops them.
// The head packet is presented show-ahead on D_pop while pndng is high.
// Sticky overflow/underflow flags and a saturating drop counter record
// misuse and can be cleared by clr_flags.

module bus_port_fifo #(
    parameter int PCKG_SZ = 16,
    parameter int DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [PCKG_SZ-1:0]           wr_data,
    input  logic                         pop,
    output logic [PCKG_SZ-1:0]           D_pop,
    output logic                         pndng,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic                         clr_flags,
    output logic                         overflow,
    output logic                         underflow,
    output logic [7:0]                   drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [PCKG_SZ-1:0] mem [DEPTH];
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic               is_empty;
    logic               do_wr;
    logic               do_pop;
    logic               drop;
    logic               empty_pop;

    // Status and handshake decode, all derived from the registered count
    always_comb begin
        is_empty  = (count == '0);
        full      = (count == DEPTH_CNT);
        pndng     = !is_empty;
        do_pop    = pop && !is_empty;
        do_wr     = wr_en && (!full || pop);
        drop      = wr_en && full && !pop;
        empty_pop = pop && is_empty;
        D_pop     = pndng ? mem[rd_ptr] : '0;
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Packet storage, written only at the write pointer on accepted writes
    always_ff @(posedge clk) begin
        if (reset && do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Sticky flags and drop counter; a clear takes effect before same-cycle events
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            drop_cnt  <= 8'd0;
        end else if (clr_flags) begin
            overflow  <= drop;
            underflow <= empty_pop;
            drop_cnt  <= drop ? 8'd1 : 8'd0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (empty_pop) begin
                underflow <= 1'b1;
            end
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule
